mp_addsub_seq: RTL
==================

Name: mp_addsub_seq

Overview:
- Multi-precision add/subtract sequencer built around a single fullAddSub_mux_16b instance, which it instantiates internally.
- Accepts two operands of WORDS x 16 bits, then feeds one 16-bit slice per cycle to the adder, least-significant slice first.
- Chains the carry (or borrow) between slices through a register and assembles the full result.
- Sits between the instruction/control logic and the 16-bit adder datapath. It lets wide arithmetic reuse one narrow adder, with valid/ready handshakes on both sides.

Parameters:
- WORDS, 4, number of 16-bit slices per operand. Operand width is 16*WORDS; legal range is 2 to 16.

Ports:
- clk  input  1  sole clock; everything updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start_valid  input  1  request carries a valid operation.
- start_ready  output  1  block can accept a request (high only in IDLE).
- op_sub  input  1  0 = add, 1 = subtract (A - B). Sampled at accept.
- opA  input  16*WORDS  operand A. Sampled at accept.
- opB  input  16*WORDS  operand B. Sampled at accept.
- res_valid  output  1  result, c_out and overflow are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  16*WORDS  sum or difference.
- c_out  output  1  carry out of the top slice. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the full-width operation.

Behaviour:
- Datapath contract:
  - The adder instance computes inA + (add_sub_sel ? ~inB : inB) + c_in.
  - add_sub_sel is driven from the captured op_sub.
- States: IDLE, RUN, DONE. Binary encoding; the state register is reset.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: capture opA, opB and op_sub; set idx=0; load the carry register with op_sub (1 for subtract, 0 for add); go to RUN.
- RUN:
  - The adder sees slice idx of A and B, with c_in from the carry register.
  - At each edge: store adder out into result slice idx, store c_out into the carry register, then idx++.
  - When the slice just stored is idx == WORDS-1: latch c_out and overflow and go to DONE.
  - start_valid is ignored during RUN.
- Latency: res_valid rises exactly WORDS cycles after the accept edge. With WORDS=4 that is the 4th edge after accept.
- DONE:
  - res_valid=1; result, c_out and overflow are held stable.
  - On res_valid & res_ready: go to IDLE, and res_valid drops on that edge.
  - A new request can be accepted no earlier than the cycle after the handshake, so throughput is 1 op per WORDS+2 cycles.
- Overflow is computed from the top slice only. Let sa = A msb, sb = effective B msb (inverted for subtract), sr = result msb. Then overflow = (sa == sb) & (sr != sa).
- Width rules:
  - idx is a counter of ceil(log2(WORDS)) bits, minimum 1 bit.
  - No wrap is visible: the transition to DONE happens at idx == WORDS-1.
- Reset, in any state including mid-RUN:
  - Next state is IDLE; captured operands are discarded.
  - All outputs go to their reset values: start_ready=1 (IDLE), res_valid=0, result=0, c_out=0, overflow=0.
  - idx=0 and the carry register = 0.
- Simultaneous events:
  - rst has priority over every handshake.
  - start_valid held high in DONE has no effect.
  - res_ready asserted outside DONE has no effect.
- result, c_out and overflow are registered outputs. They change only at RUN slice writes or reset, and must not glitch during DONE.

Test Plan:
- Add with carry across slices, WORDS=4: A=0x0000_0000_0000_FFFF, B=0x1, op_sub=0 -> result=0x0000_0000_0001_0000, c_out=0, overflow=0; res_valid on the 4th edge after accept.
- Carry out of the full width: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, add -> result=0x0, c_out=1, overflow=0.
- Subtract with borrow: A=0x0, B=0x1, op_sub=1 -> result=0xFFFF_FFFF_FFFF_FFFF, c_out=0, overflow=0. Also A=5, B=3 -> result=2, c_out=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, add -> result=0x8000_0000_0000_0000, overflow=1, c_out=0. Also A=0x8000_0000_0000_0000, B=1, sub -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Backpressure:
  - Hold res_ready=0 for 3 cycles in DONE -> result stable, res_valid=1, start_ready=0, and a pending start_valid is not accepted.
  - Raise res_ready -> IDLE on the next edge, and the pending request is accepted on the following edge.
- Reset mid-operation: assert rst for 1 cycle at RUN idx=2 -> next cycle start_ready=1, res_valid=0, result=0. A following add 1+1 completes with result=2 and c_out=0, with no stale carry.

Source files
------------

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS 16-bit slices through one
// shared 16-bit adder, least-significant slice first, chaining carry/borrow.

module fullAddSub_mux_16b (
    input  logic [15:0] inA,
    input  logic [15:0] inB,
    input  logic        add_sub_sel,
    input  logic        c_in,
    output logic [15:0] out,
    output logic        c_out
);
    logic [15:0] w_b_eff;
    logic [16:0] w_total;

    assign w_b_eff = add_sub_sel ? ~inB : inB;
    assign w_total = {1'b0, inA} + {1'b0, w_b_eff} + {16'd0, c_in};
    assign out     = w_total[15:0];
    assign c_out   = w_total[16];
endmodule

module mp_addsub_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 op_sub,
    input  logic [16*WORDS-1:0]  opA,
    input  logic [16*WORDS-1:0]  opB,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [16*WORDS-1:0]  result,
    output logic                 c_out,
    output logic                 overflow
);
    localparam int IDXW = (WORDS <= 2) ? 1 : $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDXW-1:0]        r_idx;
    logic                   r_carry;
    logic                   r_sub;
    logic [WORDS-1:0][15:0] r_a;
    logic [WORDS-1:0][15:0] r_b;
    logic [WORDS-1:0][15:0] r_result;
    logic                   r_c_out;
    logic                   r_ovf;
    logic                   r_start_ready;
    logic                   r_res_valid;

    logic [15:0] w_a_slice;
    logic [15:0] w_b_slice;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_sb;
    logic        w_ovf;

    assign w_a_slice = r_a[r_idx];
    assign w_b_slice = r_b[r_idx];

    fullAddSub_mux_16b u_adder (
        .inA         (w_a_slice),
        .inB         (w_b_slice),
        .add_sub_sel (r_sub),
        .c_in        (r_carry),
        .out         (w_sum),
        .c_out       (w_cout)
    );

    // Signed overflow only matters on the top slice: compare sign bits of A, effective B and sum.
    assign w_sb  = w_b_slice[15] ^ r_sub;
    assign w_ovf = (w_a_slice[15] == w_sb) & (w_sum[15] != w_a_slice[15]);

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= {IDXW{1'b0}};
            r_carry       <= 1'b0;
            r_sub         <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_c_out       <= 1'b0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a           <= opA;
                        r_b           <= opB;
                        r_sub         <= op_sub;
                        r_carry       <= op_sub;
                        r_idx         <= {IDXW{1'b0}};
                        r_start_ready <= 1'b0;
                        r_state       <= S_RUN;
                    end else begin
                        r_start_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= w_sum;
                    r_carry         <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= {IDXW{1'b0}};
                        r_c_out     <= w_cout;
                        r_ovf       <= w_ovf;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_res_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_start_ready <= 1'b1;
                    r_res_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign res_valid   = r_res_valid;
    assign result      = r_result;
    assign c_out       = r_c_out;
    assign overflow    = r_ovf;
endmodule
